// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter
//   Round-robin arbiter and sequencer in front of a single sequential signed
//   Booth multiplier shared by N requesters. One job is in flight at a time:
//   accept operands from the granted requester, pulse mul_start, wait for
//   mul_done (or a timeout), then return the product over a valid/ready
//   response to the same requester.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester job handshake (req_ready one-hot, IDLE only)
//   req_a/req_b             packed signed operands, slice i = [i*W +: W]
//   rsp_valid/rsp_ready     per-requester response handshake (rsp_valid one-hot)
//   rsp_product, rsp_err    registered result; product forced to 0 on timeout
//   busy                    high in every state except IDLE
//   mul_start, mul_a, mul_b multiplier controls, owned entirely by this block
//   mul_product, mul_done   multiplier result; done is sticky until next start
module booth_mult_arbiter #(
  parameter int N       = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   rsp_valid,
  input  logic [N-1:0]   rsp_ready,
  output logic [2*W-1:0] rsp_product,
  output logic           rsp_err,
  output logic           busy,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_product,
  input  logic           mul_done
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SETTLE,
    BUSY,
    RESP
  } state_t;

  state_t                state, state_nxt;
  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        gnt_id;
  logic [IDW-1:0]        gnt_cmb;
  logic                  gnt_found;
  logic [TW-1:0]         timer;
  logic signed [W-1:0]   a_q;
  logic signed [W-1:0]   b_q;
  logic signed [2*W-1:0] prod_q;
  logic                  err_q;
  logic                  rsp_hs;
  logic                  timeout_hit;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_cmb   = rr_ptr;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_cmb   = IDW'(idx);
      end
    end
  end

  assign rsp_hs      = (state == RESP) && rsp_ready[gnt_id];
  // Timer counts BUSY cycles from 0, so the last allowed cycle sees TIMEOUT-1.
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    case (state)
      IDLE: begin
        // Gated by rst_n so req_ready reads 0 while reset is held.
        if (gnt_found && rst_n) begin
          req_ready[gnt_cmb] = 1'b1;
          state_nxt          = LAUNCH;
        end
      end
      LAUNCH: state_nxt = SETTLE;
      // mul_done may still be high from the previous job here; it is ignored.
      SETTLE: state_nxt = BUSY;
      BUSY: begin
        if (mul_done || timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid[gnt_id] = 1'b1;
        if (rsp_hs) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign mul_start   = (state == LAUNCH);
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign rsp_product = prod_q;
  assign rsp_err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt_id <= '0;
      timer  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            gnt_id <= gnt_cmb;
            a_q    <= req_a[gnt_cmb*W +: W];
            b_q    <= req_b[gnt_cmb*W +: W];
          end
        end
        SETTLE: timer <= '0;
        BUSY: begin
          // Done has priority over a timeout in the same cycle.
          if (mul_done) begin
            prod_q <= mul_product;
            err_q  <= 1'b0;
          end else if (timeout_hit) begin
            prod_q <= '0;
            err_q  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            rr_ptr <= (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Testbench for booth_mult_arbiter: table of single jobs plus hand-written
// reset-mid-job and contention sequences, with a scoreboard queue of
// expected responses and a behavioural multiplier model.
module tb_booth_mult_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [2*W-1:0] rsp_product;
  logic           rsp_err;
  logic           busy;
  logic           mul_start;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] mul_product;
  logic           mul_done;

  booth_mult_arbiter #(.N(N), .W(W), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
    .rsp_err(rsp_err), .busy(busy), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: done visible 5 cycles after the start cycle, sticky.
  // mode 0 normal, 1 old done/product linger one extra cycle after start,
  // 2 never signals done.
  int              mode = 0;
  int              mcnt = 0;
  logic            mdone = 1'b0;
  logic            clr_pend = 1'b0;
  logic [7:0]      mprod = 8'h00;
  logic signed [7:0] ea, eb;
  assign ea = {{4{mul_a[3]}}, mul_a};
  assign eb = {{4{mul_b[3]}}, mul_b};
  assign mul_done    = mdone;
  assign mul_product = mprod;

  always @(posedge clk) begin
    if (mul_start) begin
      mcnt <= 4;
      if (mode == 1) clr_pend <= 1'b1;
      else           mdone    <= 1'b0;
    end else begin
      if (clr_pend) begin
        mdone    <= 1'b0;
        clr_pend <= 1'b0;
      end
      if (mcnt > 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1 && mode != 2) begin
          mdone <= 1'b1;
          mprod <= ea * eb;
        end
      end
    end
  end

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] prod;
    logic       err;
    int         lat;
    int         hold;
    int         mode;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] prod;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pop_check(output exp_t got);
    logic [N-1:0] oh;
    got.id = 0; got.prod = '0; got.err = 1'b0;
    if (sb.size() == 0) begin
      fail_now("scoreboard_empty");
    end else begin
      got = sb.pop_front();
      oh = '0;
      oh[got.id] = 1'b1;
      check("rsp_valid", rsp_valid, oh);
      check("rsp_product", rsp_product, got.prod);
      check("rsp_err", rsp_err, got.err);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [N-1:0] oh;
    int   t0, starts, w;
    exp_t e, got;
    mode = v.mode;
    oh = '0;
    oh[v.id] = 1'b1;
    req_a[v.id*W +: W] = v.a;
    req_b[v.id*W +: W] = v.b;
    req_valid = oh;
    #1;
    check("req_ready", req_ready, oh);
    t0 = cyc;
    e.id = v.id; e.prod = v.prod; e.err = v.err;
    sb.push_back(e);
    step();
    req_valid = '0;
    check("mul_start", mul_start, 1);
    check("mul_ab", {mul_a, mul_b}, {v.a, v.b});
    starts = 1;
    w = 0;
    while (rsp_valid == '0 && w < 40) begin
      step();
      w++;
      if (mul_start) starts++;
    end
    if (rsp_valid == '0) begin
      fail_now("rsp_wait_timeout");
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    check("latency", cyc - t0, v.lat);
    check("start_count", starts, 1);
    pop_check(got);
    for (int h = 0; h < v.hold; h++) begin
      rsp_ready = ~oh;
      req_valid = '1;
      step();
      check("hold_stable", {rsp_valid, rsp_product, rsp_err, mul_a, mul_b, req_ready},
            {oh, got.prod, got.err, v.a, v.b, 4'b0000});
    end
    rsp_ready = oh;
    req_valid = '0;
    step();
    rsp_ready = '0;
    check("back_idle", {busy, rsp_valid}, 0);
  endtask

  vec_t vecs[7];
  int   order[5];
  logic [7:0] cprod[4];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e, got;
    int   k, r, starts;
    logic [N-1:0] oh;

    vecs[0] = '{2, 4'h3, 4'hE, 8'hFA, 1'b0, 7,  0,  0};
    vecs[1] = '{0, 4'h7, 4'h7, 8'h31, 1'b0, 7,  0,  0};
    vecs[2] = '{1, 4'h8, 4'h8, 8'h40, 1'b0, 7,  10, 0};
    vecs[3] = '{3, 4'h8, 4'h7, 8'hC8, 1'b0, 7,  0,  1};
    vecs[4] = '{0, 4'h5, 4'hD, 8'h00, 1'b1, 19, 0,  2};
    vecs[5] = '{2, 4'hF, 4'hF, 8'h01, 1'b0, 7,  0,  0};
    vecs[6] = '{1, 4'h0, 4'hB, 8'h00, 1'b0, 7,  2,  0};
    order   = '{0, 1, 2, 3, 0};
    cprod   = '{8'hFD, 8'hFA, 8'hF7, 8'hF4};

    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = '0;
    repeat (3) step();
    check("reset_outs", {req_ready, rsp_valid, rsp_product, rsp_err, busy, mul_start, mul_a, mul_b}, 0);
    rst_n = 1'b1;
    step();
    check("idle_after_reset", {req_ready, rsp_valid, busy, mul_start}, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset pulsed while a job sits in BUSY.
    mode = 0;
    req_a[3*W +: W] = 4'h2;
    req_b[3*W +: W] = 4'h3;
    req_valid = 4'b1000;
    #1;
    check("rst_job_grant", req_ready, 4'b1000);
    step();
    req_valid = '0;
    repeat (3) step();
    check("busy_before_rst", busy, 1);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 4'(i + 1);
      req_b[i*W +: W] = 4'hD;
    end
    req_valid = '1;
    rsp_ready = '1;
    #1;
    check("async_reset_outs", {req_ready, rsp_valid, rsp_product, rsp_err, busy, mul_start, mul_a, mul_b}, 0);
    step();
    step();
    rst_n = 1'b1;
    #1;

    // Contention: all requesting, responses always accepted.
    k = 0;
    r = 0;
    starts = 0;
    for (int c = 0; c < 100 && r < 5; c++) begin
      if (req_ready != '0) begin
        if (k < 5) begin
          oh = '0;
          oh[order[k]] = 1'b1;
          check("grant_order", req_ready, oh);
          e.id = order[k]; e.prod = cprod[order[k]]; e.err = 1'b0;
          sb.push_back(e);
          k++;
        end
        starts = 0;
      end
      if (mul_start) starts++;
      if (rsp_valid != '0) begin
        check("one_start_per_job", starts, 1);
        pop_check(got);
        r++;
      end
      step();
    end
    if (r < 5) fail_now("contention_timeout");

    req_valid = '0;
    rsp_ready = '0;
    step();
    step();
    check("final_idle", busy, 0);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
